// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the fetch/data memory-port arbiter:
//   - address/data width defaults (tied to the core's ISIZE/DSIZE)
//   - starvation counter width
//   - encoding of the "access issued last cycle" state
//   - helper that derives the next state from the current grants
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int ISIZE  = 16;          // instruction address width of the core
    localparam int DSIZE  = 16;          // data word width of the core
    localparam int AW_DEF = ISIZE;
    localparam int DW_DEF = DSIZE;

    localparam int          CNT_W   = 3;
    localparam logic [2:0]  CNT_SAT = 3'd7;

    // State records which access went to memory in the previous cycle, so the
    // response (one cycle later) can be steered to the right requester.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        DM_RD = 2'd2,
        DM_WR = 2'd3
    } state_e;

    function automatic state_e next_state(input logic if_gnt,
                                          input logic dm_gnt,
                                          input logic dm_wen);
        if (if_gnt)      return IF_RD;
        else if (dm_gnt) return dm_wen ? DM_WR : DM_RD;
        else             return IDLE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
//   3-bit saturating counter of consecutive cycles in which fetch was
//   requesting but the data port won. o_hit flags that the count has reached
//   STARVE_MAX, at which point the top lets fetch win.
//
//   Ports
//     i_clk  : clock, rising edge
//     i_rst  : asynchronous active-low reset (clears the count)
//     i_inc  : fetch denied in favour of the data port this cycle
//     i_clr  : fetch granted or not requesting this cycle (clear wins)
//     o_hit  : count == STARVE_MAX
// ---------------------------------------------------------------------------
module arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_SAT)) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_hit = (r_cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Arbitrates a single-ported synchronous memory between an instruction
//   fetch port (read only) and a data port (read/write). The data port wins
//   by default; after STARVE_MAX consecutive fetch denials fetch is forced
//   through for one cycle. Grants are combinational, reads return one cycle
//   after the address, and a grant may be issued every cycle.
//
//   Ports
//     i_clk, i_rst            : clock / asynchronous active-low reset
//     i_if_req, i_if_addr     : fetch request and address (PC)
//     o_if_gnt                : fetch granted this cycle
//     o_if_rvalid, o_if_rdata : fetch read response (data 0 when not valid)
//     i_dm_req, i_dm_wen      : data request, write(1)/read(0)
//     i_dm_addr, i_dm_wdata   : data address / write data
//     o_dm_gnt                : data port granted this cycle
//     o_dm_rvalid, o_dm_rdata : data read response (data 0 when not valid)
//     o_mem_wen, o_mem_addr,
//     o_mem_wdata             : memory drive from the granted requester
//     i_mem_rdata             : memory read data, one cycle after address
//     o_stall_if              : fetch must hold PC (requested, not granted)
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [DW-1:0] o_if_rdata,
    input  logic          i_dm_req,
    input  logic          i_dm_wen,
    input  logic [AW-1:0] i_dm_addr,
    input  logic [DW-1:0] i_dm_wdata,
    output logic          o_dm_gnt,
    output logic          o_dm_rvalid,
    output logic [DW-1:0] o_dm_rdata,
    output logic          o_mem_wen,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_stall_if
);

    state_e r_state;
    state_e w_state_nxt;
    logic   w_starve_hit;
    logic   w_if_gnt;
    logic   w_dm_gnt;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (i_if_req && i_dm_req && w_dm_gnt),
        .i_clr (w_if_gnt || !i_if_req),
        .o_hit (w_starve_hit)
    );

    // Grants are gated by i_rst directly so nothing reaches the memory while
    // reset is held, whatever the requesters are doing.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (i_rst) begin
            if (i_if_req && (w_starve_hit || !i_dm_req)) begin
                w_if_gnt = 1'b1;
            end else if (i_dm_req) begin
                w_dm_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_if_gnt) begin
            o_mem_addr  = i_if_addr;
        end else if (w_dm_gnt) begin
            o_mem_wen   = i_dm_wen;
            o_mem_addr  = i_dm_addr;
            o_mem_wdata = i_dm_wdata;
        end
    end

    always_comb begin
        w_state_nxt = next_state(w_if_gnt, w_dm_gnt, i_dm_wen);
    end

    // Asynchronous reset also discards any read in flight: the state drops to
    // IDLE, so no rvalid can follow the release of reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_dm_gnt    = w_dm_gnt;
    assign o_stall_if  = i_if_req && !w_if_gnt;

    assign o_if_rvalid = (r_state == IF_RD);
    assign o_dm_rvalid = (r_state == DM_RD);
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench. A reference arbiter (own starvation count) predicts
//   grants and memory drive each cycle; the expected response owner is pushed
//   to a queue when the stimulus is driven and popped the next cycle, when the
//   DUT must present it. Read data is compared against the value the bench
//   itself drives on mem_rdata.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SM = 3;

    typedef enum logic [1:0] {R_NONE, R_IF, R_DM} resp_e;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_wen;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;

    int    n_checks = 0;
    int    n_errors = 0;
    resp_e sb_q[$];
    int    ref_cnt;

    mem_port_arbiter #(
        .AW (AW), .DW (DW), .STARVE_MAX (SM)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .i_dm_req    (dm_req),
        .i_dm_wen    (dm_wen),
        .i_dm_addr   (dm_addr),
        .i_dm_wdata  (dm_wdata),
        .o_dm_gnt    (dm_gnt),
        .o_dm_rvalid (dm_rvalid),
        .o_dm_rdata  (dm_rdata),
        .o_mem_wen   (mem_wen),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_stall_if  (stall_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle. Called just after a rising edge; drives inputs, checks
    // combinational outputs and the due response at the falling edge, then
    // advances the reference model and returns just after the next edge.
    task automatic step(input logic          ireq,
                        input logic [AW-1:0] iaddr,
                        input logic          dreq,
                        input logic          dwen,
                        input logic [AW-1:0] daddr,
                        input logic [DW-1:0] dwdata,
                        input logic [DW-1:0] rdata);
        resp_e   due;
        logic    force_if, e_if, e_dm;
        logic [AW-1:0] e_addr;
        if_req    = ireq;
        if_addr   = iaddr;
        dm_req    = dreq;
        dm_wen    = dwen;
        dm_addr   = daddr;
        dm_wdata  = dwdata;
        mem_rdata = rdata;
        due       = (sb_q.size() > 0) ? sb_q.pop_front() : R_NONE;
        force_if  = (ref_cnt == SM) && ireq;
        e_if      = ireq && (!dreq || force_if);
        e_dm      = dreq && !force_if;
        e_addr    = e_if ? iaddr : (e_dm ? daddr : '0);
        @(negedge clk);
        check("if_gnt",    if_gnt,    e_if);
        check("dm_gnt",    dm_gnt,    e_dm);
        check("stall_if",  stall_if,  ireq && !e_if);
        check("mem_wen",   mem_wen,   e_dm && dwen);
        check("mem_addr",  mem_addr,  e_addr);
        check("mem_wdata", mem_wdata, e_dm ? dwdata : '0);
        check("if_rvalid", if_rvalid, due == R_IF);
        check("if_rdata",  if_rdata,  (due == R_IF) ? rdata : '0);
        check("dm_rvalid", dm_rvalid, due == R_DM);
        check("dm_rdata",  dm_rdata,  (due == R_DM) ? rdata : '0);
        sb_q.push_back(e_if ? R_IF : ((e_dm && !dwen) ? R_DM : R_NONE));
        if (e_if || !ireq)            ref_cnt = 0;
        else if (dreq && e_dm && ref_cnt < 7) ref_cnt = ref_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [DW-1:0] rdata);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, rdata);
    endtask

    task automatic model_reset();
        sb_q.delete();
        ref_cnt = 0;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b1; if_addr = 16'h1111;
        dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 16'h2222; dm_wdata = 16'h3333;
        mem_rdata = 16'hBEEF;
        model_reset();

        // Reset held with both requests active: nothing granted or returned.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst if_gnt",    if_gnt,    1'b0);
        check("rst dm_gnt",    dm_gnt,    1'b0);
        check("rst mem_wen",   mem_wen,   1'b0);
        check("rst if_rvalid", if_rvalid, 1'b0);
        check("rst dm_rvalid", dm_rvalid, 1'b0);
        check("rst if_rdata",  if_rdata,  '0);
        check("rst dm_rdata",  dm_rdata,  '0);
        check("rst state",     32'(dut.r_state),       32'(IDLE));
        check("rst starve",    32'(dut.u_starve.r_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Fetch alone, granted in the first cycle out of reset.
        step(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, 16'h0000);
        step(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, 16'hA001);
        step(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, 16'hA002);
        idle(16'hA003);

        // Contention, both reading: DM, DM, DM, IF (forced), DM.
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0030, '0, 16'hC000 + 16'(i));
        idle(16'hC0FF);

        // Write: memory driven in the grant cycle, no read response after it.
        step(1'b0, '0, 1'b1, 1'b1, 16'h0020, 16'h1234, 16'h5555);
        idle(16'h6666);

        // Alternating DM read then IF read.
        step(1'b0, '0, 1'b1, 1'b0, 16'h0005, '0, 16'h0000);
        step(1'b1, 16'h0006, 1'b0, 1'b0, '0, '0, 16'hD005);
        idle(16'hD006);

        // Random mixed traffic, including writes under contention.
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom), 16'($urandom));
        idle(16'h0BAD);

        // Reset asserted while a DM read is in flight.
        dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 16'h0077; if_req = 1'b0;
        @(negedge clk);
        check("mid dm_gnt", dm_gnt, 1'b1);
        #1;
        rst = 1'b0;
        if_req = 1'b1;
        @(posedge clk);
        #1;
        check("mid if_gnt",    if_gnt,    1'b0);
        check("mid dm_gnt rst", dm_gnt,   1'b0);
        check("mid dm_rvalid", dm_rvalid, 1'b0);
        check("mid dm_rdata",  dm_rdata,  '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        check("rel state",  32'(dut.r_state),        32'(IDLE));
        check("rel starve", 32'(dut.u_starve.r_cnt), 0);
        idle(16'h7777);
        // Contention again from a cleared counter: three DM wins then IF.
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, '0, 16'hE000 + 16'(i));
        idle(16'hE0FF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 16, address width, matching ISIZE.
REQ-002 Parameter DW, default 16, data width, matching DSIZE.
REQ-003 Parameter STARVE_MAX, default 3, range 1..7; consecutive fetch denials before fetch is forced to win.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port if_req, input, 1, instruction-fetch read request.
REQ-008 Port if_addr, input, AW, fetch address (PC).
REQ-009 Port if_gnt, output, 1, fetch granted this cycle.
REQ-010 Port if_rvalid, output, 1, fetch read data valid.
REQ-011 Port if_rdata, output, DW, fetch read data.
REQ-012 Port dm_req, input, 1, data-port request.
REQ-013 Port dm_wen, input, 1, data-port request is a write (1) or a read (0).
REQ-014 Port dm_addr, input, AW, data address.
REQ-015 Port dm_wdata, input, DW, data to write.
REQ-016 Port dm_gnt, output, 1, data port granted this cycle.
REQ-017 Port dm_rvalid, output, 1, data read data valid.
REQ-018 Port dm_rdata, output, DW, data read data.
REQ-019 Port mem_wen, output, 1, write enable to the shared memory.
REQ-020 Port mem_addr, output, AW, address to the shared memory.
REQ-021 Port mem_wdata, output, DW, write data to the shared memory.
REQ-022 Port mem_rdata, input, DW, read data from the shared memory, valid one cycle after the address.
REQ-023 Port stall_if, output, 1, fetch must hold PC; equals if_req AND NOT if_gnt.

Function
REQ-024 At most one of if_gnt or dm_gnt SHALL be high in any cycle.
- Grants are combinational from the requests and current state.
- A grant is never issued without its request.

REQ-025 Priority SHALL be as follows.
- The data port wins by default.
- When starve_cnt equals STARVE_MAX and if_req is high, fetch wins.

REQ-026 starve_cnt SHALL update as follows.
- Increments, saturating, when if_req, dm_req and dm_gnt are all high.
- Clears when if_gnt is high or if_req is low.

REQ-027 Memory drive SHALL follow the grant.
- mem_addr, mem_wdata and mem_wen come from the granted requester.
- With no grant: mem_wen=0, mem_addr=0, mem_wdata=0.
- mem_wen=1 only when dm_gnt and dm_wen are both high.

REQ-028 The FSM state SHALL record the access issued in the previous cycle; the states are IDLE, IF_RD, DM_RD and DM_WR.
- Next state is IF_RD on if_gnt.
- Next state is DM_RD on dm_gnt with dm_wen=0.
- Next state is DM_WR on dm_gnt with dm_wen=1.
- Otherwise next state is IDLE.

REQ-029 Read latency SHALL be one cycle.
- if_rvalid=1 exactly when the state is IF_RD.
- dm_rvalid=1 exactly when the state is DM_RD.
- DM_WR SHALL produce no rvalid.

REQ-030 if_rdata and dm_rdata SHALL pass mem_rdata when their rvalid is high, and be 0 otherwise.

REQ-031 Back-to-back grants SHALL be permitted every cycle, with full throughput. The response to cycle N overlaps the grant of cycle N+1.

REQ-032 If a requester drops its request, the arbiter SHALL take no action. No request is ever retained internally.

Reset
REQ-033 While rst=0, the block SHALL be forced as follows.
- State is IDLE and starve_cnt is 0.
- if_rvalid, dm_rvalid, if_rdata and dm_rdata are 0.
- Grants and mem_wen are 0, regardless of the request inputs.

REQ-034 A read in flight when reset asserts SHALL be discarded; no rvalid appears after reset is released.

REQ-035 The first grant SHALL be possible in the first cycle in which rst=1.

Structure
REQ-036 A shared package SHALL hold the following.
- The state enumeration: IDLE=2'd0, IF_RD=2'd1, DM_RD=2'd2, DM_WR=2'd3.
- The AW/DW defaults, tied to ISIZE/DSIZE.

REQ-037 One sub-module, arb_starve_ctr, SHALL implement the 3-bit saturating starvation counter and its compare against STARVE_MAX.

REQ-038 The RTL target SHALL be 150-250 lines, with no memories inside.

Verification
REQ-039 Fetch alone: if_req=1, if_addr=0x0010 for 3 cycles; mem_rdata=0xA001,0xA002,0xA003.
- if_gnt=1 in every cycle.
- if_rvalid=1 in cycles 2-4, with if_rdata=0xA001,0xA002,0xA003.
- stall_if=0 throughout.

REQ-040 Contention with STARVE_MAX=3: if_req and dm_req (read) held high for 5 cycles.
- dm_gnt in cycles 1-3, if_gnt in cycle 4, dm_gnt in cycle 5.
- stall_if=1 in cycles 1-3.

REQ-041 Write: dm_req=1, dm_wen=1, dm_addr=0x0020, dm_wdata=0x1234.
- mem_wen=1, mem_addr=0x0020, mem_wdata=0x1234 in the same cycle.
- dm_rvalid stays 0 in the next cycle.

REQ-042 Reset mid-read: DM read granted, then rst=0 asserted before the next rising edge.
- dm_rvalid never rises.
- State is IDLE and starve_cnt is 0 after release.

REQ-043 Alternating traffic: DM read to 0x0005 in cycle 1, IF read to 0x0006 in cycle 2.
- dm_rvalid in cycle 2 returns the cycle-1 data.
- if_rvalid in cycle 3 returns the cycle-2 data.
- The two rvalids are never high together.
